window_scan_ctrl: RTL
=====================

Name: window_scan_ctrl

Overview:
- Sequences the sliding-window scan of the Haar detector across one frame.
- Steps the window origin (win_x, win_y) in raster order with a programmable stride.
- For each position, hands one window to the cascade classifier with a start/done handshake and reports any face hits.
- Sits between the frame-level control FSM and the classifier. Stride counters wrap at programmable maxima.

Parameters:
- DATA_WIDTH, 8, width of coordinates, maxima and stride.
- CNT_WIDTH, 16, width of the performance counters (used only with SCAN_PERF_EN).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin frame scan; sampled only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE from any state.
- max_x  input  DATA_WIDTH  last legal window x origin, inclusive.
- max_y  input  DATA_WIDTH  last legal window y origin, inclusive.
- step  input  DATA_WIDTH  stride; 0 is treated as 1.
- cls_start  output  1  one-cycle pulse: classifier evaluates window at win_x/win_y.
- cls_done  input  1  classifier finished the current window.
- cls_face  input  1  classifier verdict, valid with cls_done.
- win_x  output  DATA_WIDTH  current window x origin.
- win_y  output  DATA_WIDTH  current window y origin.
- busy  output  1  high in every state except IDLE.
- face_valid  output  1  one-cycle pulse: face found at face_x/face_y.
- face_x  output  DATA_WIDTH  x of last reported face; held until the next hit.
- face_y  output  DATA_WIDTH  y of last reported face; held until the next hit.
- frame_done  output  1  one-cycle pulse: all positions evaluated.
- window_count  output  CNT_WIDTH  windows evaluated this frame (see Optional Feature).
- hit_count  output  CNT_WIDTH  faces found this frame (see Optional Feature).

Behaviour:
- Reset is asynchronous, active-high, on clk. All outputs reset to 0; state is IDLE.
- States: IDLE, ISSUE, WAIT, ADVANCE, DONE.
- IDLE:
  - win_x = win_y = 0.
  - On start=1, latch max_x, max_y and step (0 becomes 1) into shadow registers, then go to ISSUE.
  - Input changes after the latch have no effect until the next frame.
- ISSUE: assert cls_start for exactly one cycle, then go to WAIT. win_x/win_y stay stable from ISSUE until ADVANCE.
- WAIT:
  - Hold until cls_done=1. cls_done is ignored in all other states.
  - On cls_done with cls_face=1: face_valid pulses the next cycle, and face_x/face_y take the current win_x/win_y.
  - Then go to ADVANCE.
- ADVANCE:
  - Compute win_x+step at DATA_WIDTH+1 bits; the sum never wraps silently.
  - If the sum is ≤ max_x: win_x += step, go to ISSUE.
  - Else win_x = 0. Then, if win_y+step (DATA_WIDTH+1 bits) is ≤ max_y: win_y += step, go to ISSUE. Otherwise go to DONE.
- DONE: frame_done=1 for one cycle, then go to IDLE, where coordinates return to 0.
- Windows per frame: (floor(max_x/step)+1) × (floor(max_y/step)+1).
- Minimum cost per window is 3 cycles: ISSUE, WAIT with cls_done in its first cycle, ADVANCE.
- max_x=max_y=0: exactly one window at (0,0), then frame_done.
- start while busy is ignored. start in the same cycle as abort: abort wins.
- abort (any state):
  - Next cycle the block is in IDLE with win_x=win_y=0.
  - No frame_done, face_valid or cls_start is issued in that cycle.
  - A pending classifier result is discarded.
- Reset mid-scan: same effect as abort, and face_x/face_y are also cleared.

Optional Feature:
- Macro SCAN_PERF_EN.
- Defined:
  - window_count increments on each accepted cls_done.
  - hit_count increments on each accepted cls_done with cls_face=1.
  - Both saturate at all-ones.
  - Both clear on reset and on leaving IDLE for a new frame; they hold their values after frame_done for readout.
- Undefined: window_count and hit_count are tied to 0, no counter registers are inferred, and all other behaviour is identical.

Test Plan:
- max_x=3, max_y=1, step=1, cls_done 1 cycle after each cls_start -> 8 cls_start pulses at (0,0),(1,0),(2,0),(3,0),(0,1),(1,1),(2,1),(3,1); one frame_done; busy low afterwards; window_count=8 with SCAN_PERF_EN.
- max_x=4, max_y=2, step=2 -> 6 windows, x∈{0,2,4}, y∈{0,2}. Repeat with step=0 -> 15 windows, identical to step=1.
- max_x=255, max_y=0, step=200 -> windows at x=0 and x=200 only; no overflow to x=144; frame_done after 2.
- cls_face=1 only at (2,0) in the first scenario -> one face_valid pulse with face_x=2, face_y=0, held through frame end; hit_count=1.
- abort in WAIT at (1,0) with cls_done asserted the same cycle -> IDLE next cycle; no face_valid; no frame_done. A new start restarts at (0,0).
- Assert reset while in ISSUE; start pulsed while busy -> outputs 0 immediately on reset; the start while busy causes no restart or extra cls_start.

Source files
------------

// File: rtl/window_scan_ctrl_if.sv
// Frame-control / classifier-side signal bundle for window_scan_ctrl.
// slave: the scan controller's view; master: the environment driving it.
interface window_scan_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  start;
  logic                  abort;
  logic [DATA_WIDTH-1:0] max_x;
  logic [DATA_WIDTH-1:0] max_y;
  logic [DATA_WIDTH-1:0] step;
  logic                  cls_start;
  logic                  cls_done;
  logic                  cls_face;
  logic [DATA_WIDTH-1:0] win_x;
  logic [DATA_WIDTH-1:0] win_y;
  logic                  busy;
  logic                  face_valid;
  logic [DATA_WIDTH-1:0] face_x;
  logic [DATA_WIDTH-1:0] face_y;
  logic                  frame_done;
  logic [CNT_WIDTH-1:0]  window_count;
  logic [CNT_WIDTH-1:0]  hit_count;

  modport slave (
    input  start, abort, max_x, max_y, step, cls_done, cls_face,
    output cls_start, win_x, win_y, busy, face_valid, face_x, face_y,
           frame_done, window_count, hit_count
  );

  modport master (
    output start, abort, max_x, max_y, step, cls_done, cls_face,
    input  cls_start, win_x, win_y, busy, face_valid, face_x, face_y,
           frame_done, window_count, hit_count
  );
endinterface

// File: rtl/window_scan_ctrl.sv
// Sliding-window scan sequencer: walks the window origin in raster order with
// a programmable stride and hands each position to the cascade classifier.
// Optional macro SCAN_PERF_EN adds saturating per-frame window/hit counters;
// without it both counters read 0 and no counter state exists.
module window_scan_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input logic               clk,
  input logic               reset,
  window_scan_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ADVANCE, DONE} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] cur_x, cur_y;
  logic [DATA_WIDTH-1:0] lim_x, lim_y, stride;
  logic [DATA_WIDTH-1:0] hit_x, hit_y;
  logic                  hit_pulse;
  // One extra bit so a stride past the top of the range never wraps back in.
  logic [DATA_WIDTH:0]   sum_x, sum_y;
  logic                  x_fits, y_fits, accept, launch;

  // Next-state logic plus the row/column fit decisions used in ADVANCE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    launch    = 1'b0;
    sum_x     = {1'b0, cur_x} + {1'b0, stride};
    sum_y     = {1'b0, cur_y} + {1'b0, stride};
    x_fits    = (sum_x <= {1'b0, lim_x});
    y_fits    = (sum_y <= {1'b0, lim_y});
    case (state)
      IDLE: if (bus.start) begin
        state_nxt = ISSUE;
        launch    = 1'b1;
      end
      ISSUE: state_nxt = WAIT;
      WAIT: if (bus.cls_done) begin
        state_nxt = ADVANCE;
        accept    = 1'b1;
      end
      ADVANCE: state_nxt = (x_fits || y_fits) ? ISSUE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort beats everything, including a start or a result in this cycle.
    if (bus.abort) begin
      state_nxt = IDLE;
      accept    = 1'b0;
      launch    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Snapshot the frame geometry at start so later input changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lim_x  <= '0;
      lim_y  <= '0;
      stride <= '0;
    end else if (launch) begin
      lim_x  <= bus.max_x;
      lim_y  <= bus.max_y;
      stride <= (bus.step == '0) ? DATA_WIDTH'(1) : bus.step;
    end
  end

  // Window origin: raster step in ADVANCE, zero whenever heading to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_x <= '0;
      cur_y <= '0;
    end else if (state_nxt == IDLE) begin
      cur_x <= '0;
      cur_y <= '0;
    end else if (state == ADVANCE) begin
      if (x_fits) begin
        cur_x <= sum_x[DATA_WIDTH-1:0];
      end else begin
        cur_x <= '0;
        if (y_fits) cur_y <= sum_y[DATA_WIDTH-1:0];
      end
    end
  end

  // Face report: pulse the cycle after an accepted hit, coordinates held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_pulse <= 1'b0;
      hit_x     <= '0;
      hit_y     <= '0;
    end else begin
      hit_pulse <= accept && bus.cls_face;
      if (accept && bus.cls_face) begin
        hit_x <= cur_x;
        hit_y <= cur_y;
      end
    end
  end

  assign bus.cls_start  = (state == ISSUE);
  assign bus.frame_done = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.win_x      = cur_x;
  assign bus.win_y      = cur_y;
  assign bus.face_valid = hit_pulse;
  assign bus.face_x     = hit_x;
  assign bus.face_y     = hit_y;

`ifdef SCAN_PERF_EN
  logic [CNT_WIDTH-1:0] win_cnt, hit_cnt;

  // Saturating per-frame counters, cleared at frame launch, held for readout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt <= '0;
      hit_cnt <= '0;
    end else if (launch) begin
      win_cnt <= '0;
      hit_cnt <= '0;
    end else if (accept) begin
      if (~&win_cnt)                  win_cnt <= win_cnt + 1'b1;
      if (bus.cls_face && ~&hit_cnt)  hit_cnt <= hit_cnt + 1'b1;
    end
  end

  assign bus.window_count = win_cnt;
  assign bus.hit_count    = hit_cnt;
`else
  assign bus.window_count = '0;
  assign bus.hit_count    = '0;
`endif
endmodule
